wr_level_monitor: RTL and testbench
===================================

Name: wr_level_monitor

Overview:
- Write-domain companion to the async FIFO write-pointer/full logic.
- Synchronises the read-domain Gray read pointer into wclk and hands it to the full logic as wq2_rptr.
- Produces a registered fill level, an almost-full flag with hysteresis, a high-water mark and a sticky overflow flag for the write-side producer and its status registers.

Parameters:
- ps, 4, address width; FIFO depth = 2**ps; pointers are ps+1 bits.
- SYNC_STAGES, 2, number of synchroniser flops for rptr_gray; legal range >= 2.
- AF_SET, 12, level at or above which walmost_full asserts; legal range AF_CLR < AF_SET <= 2**ps.
- AF_CLR, 10, level at or below which walmost_full deasserts.

Ports:
- wclk  in  1  write clock
- wrst_n  in  1  reset; asynchronous, active-low
- rptr_gray  in  ps+1  Gray read pointer, launched from the read clock domain (asynchronous to wclk)
- wptr_gray  in  ps+1  registered Gray write pointer from the write full logic
- winc  in  1  producer write request
- wfull  in  1  registered full flag from the write full logic
- clr_hwm  in  1  clear high-water mark, single-cycle pulse
- clr_ovf  in  1  clear overflow flag, single-cycle pulse
- wq2_rptr  out  ps+1  synchronised Gray read pointer (feeds the full logic)
- wlevel  out  ps+1  entries occupied, range 0..2**ps
- walmost_full  out  1  hysteretic almost-full flag
- whwm  out  ps+1  maximum wlevel since the last clear or reset
- wovf  out  1  sticky overflow flag: a write was attempted while full

Behaviour:
- Reset (wrst_n low, asynchronous): all synchroniser flops, wq2_rptr, wlevel, walmost_full, whwm and wovf go to 0.
- Reset may assert at any cycle, including mid-burst; the block resumes from the all-zero state when reset is released.
- Synchroniser:
  - rptr_gray passes through SYNC_STAGES flops; the final flop is wq2_rptr.
  - A change in rptr_gray sampled at edge N appears on wq2_rptr after edge N+SYNC_STAGES-1.
  - No logic is placed between synchroniser stages.
- Level arithmetic:
  - Convert wptr_gray and wq2_rptr from Gray to binary: b[ps] = g[ps]; b[i] = b[i+1] ^ g[i].
  - diff = bin(wptr_gray) - bin(wq2_rptr), computed modulo 2**(ps+1); this makes pointer wrap-around transparent.
  - wlevel <= diff each cycle, so wlevel lags its inputs by 1 cycle.
  - wlevel is pessimistic: it never under-reports occupancy.
- walmost_full (registered, computed from the next wlevel value, i.e. diff):
  - set when diff >= AF_SET;
  - cleared when diff <= AF_CLR;
  - otherwise holds its value.
- whwm:
  - if clr_hwm = 1: whwm <= diff;
  - else if diff > whwm: whwm <= diff;
  - otherwise holds.
- wovf:
  - set when winc & wfull are both 1 on a clock edge;
  - cleared by clr_ovf;
  - if set and clear occur in the same cycle, set wins.
- wfull and the write pointer are not modified by this block; it only observes them.
- Integrity check: diff > 2**ps is illegal and never occurs in correct operation. A simulation assertion flags it.
- Parameter checks: illegal parameter combinations trigger an elaboration-time $error.

Decomposition:
- Package fifo_pkg holds:
  - ptr_t, typedef for a ps+1 bit pointer;
  - function gray2bin;
  - function bin2gray;
  - DEFAULT_SYNC_STAGES constant.
- One sub-module: sync_nff, a parameterised-width, parameterised-depth flop chain with asynchronous reset.
  - This block instantiates it for rptr_gray.
  - The read side reuses it for the write pointer.

Test Plan:
- Reset values: assert wrst_n low with inputs at random values -> all outputs read 0. Release reset with rptr_gray = wptr_gray = 0 -> wlevel stays 0, walmost_full stays 0.
- Fill to full (ps=4, read side idle): drive wptr_gray through Gray 1..16 (16 = 5'b11000) -> wlevel follows 1..16 with 1-cycle lag; walmost_full rises on the cycle wlevel becomes 12; whwm = 16.
- Sync latency and hysteresis: with wlevel = 16, change rptr_gray from 0 to 5'b00111 (binary 5) at edge N -> wq2_rptr updates after edge N+1; wlevel = 11 after edge N+2; walmost_full stays 1. Advance to binary 6 -> wlevel 10, walmost_full 0.
- Wrap-around: bin(wptr) = 3 (after wrap, top bit 1) and bin(wq2_rptr) = 29 -> wlevel = 6 (mod-32 arithmetic), no assertion fires.
- Overflow: winc = 1 with wfull = 1 for 1 cycle -> wovf = 1 and stays 1. Pulse clr_ovf together with another winc & wfull -> wovf remains 1. Pulse clr_ovf alone -> wovf = 0.
- HWM clear / mid-op reset: clr_hwm pulsed at wlevel = 7 -> whwm = 7. Assert wrst_n low mid-burst -> every output is 0 immediately, asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer types and Gray/binary helpers for both clock domains.
package fifo_pkg;

    localparam int PS                  = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int GRAY_W              = 32;

    typedef logic [PS:0]       ptr_t;
    typedef logic [GRAY_W-1:0] gray_w_t;

    // Helpers work on a wide zero-extended word so any pointer width up to GRAY_W can use them.
    function automatic gray_w_t gray2bin(input gray_w_t g);
        gray_w_t b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic gray_w_t bin2gray(input gray_w_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/sync_nff.sv
// Multi-flop clock-domain-crossing synchroniser with asynchronous active-low reset.
module sync_nff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Pure flop chain: nothing may sit between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/wr_level_monitor.sv
// Write-domain FIFO status: synchronised read pointer, fill level, almost-full,
// high-water mark and sticky overflow.
module wr_level_monitor
    import fifo_pkg::*;
#(
    parameter int ps          = PS,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int AF_SET      = 12,
    parameter int AF_CLR      = 10
) (
    input  logic        wclk,
    input  logic        wrst_n,
    input  logic [ps:0] rptr_gray,
    input  logic [ps:0] wptr_gray,
    input  logic        winc,
    input  logic        wfull,
    input  logic        clr_hwm,
    input  logic        clr_ovf,
    output logic [ps:0] wq2_rptr,
    output logic [ps:0] wlevel,
    output logic        walmost_full,
    output logic [ps:0] whwm,
    output logic        wovf
);

    localparam int          W        = ps + 1;
    localparam logic [ps:0] AF_SET_L = W'(AF_SET);
    localparam logic [ps:0] AF_CLR_L = W'(AF_CLR);
    localparam logic [ps:0] DEPTH_L  = W'(2 ** ps);

    if (ps < 1 || ps > GRAY_W - 2) begin : g_bad_ps
        $error("wr_level_monitor: ps=%0d out of range", ps);
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("wr_level_monitor: SYNC_STAGES=%0d must be >= 2", SYNC_STAGES);
    end
    if (AF_CLR < 0 || AF_CLR >= AF_SET || AF_SET > 2 ** ps) begin : g_bad_af
        $error("wr_level_monitor: need 0 <= AF_CLR < AF_SET <= 2**ps (AF_CLR=%0d AF_SET=%0d)",
               AF_CLR, AF_SET);
    end

    sync_nff #(
        .WIDTH  (W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rptr_gray),
        .q     (wq2_rptr)
    );

    logic [ps:0] wbin;
    logic [ps:0] rbin;
    logic [ps:0] diff;

    // Modulo-2**(ps+1) subtraction makes pointer wrap transparent; the stale
    // synchronised read pointer can only make the level read high, never low.
    assign wbin = W'(gray2bin(GRAY_W'(wptr_gray)));
    assign rbin = W'(gray2bin(GRAY_W'(wq2_rptr)));
    assign diff = wbin - rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
            whwm         <= '0;
            wovf         <= 1'b0;
        end else begin
            wlevel <= diff;

            if (diff >= AF_SET_L) begin
                walmost_full <= 1'b1;
            end else if (diff <= AF_CLR_L) begin
                walmost_full <= 1'b0;
            end

            if (clr_hwm || (diff > whwm)) begin
                whwm <= diff;
            end

            // A new overflow in the clearing cycle must not be lost.
            if (winc && wfull) begin
                wovf <= 1'b1;
            end else if (clr_ovf) begin
                wovf <= 1'b0;
            end
        end
    end

    a_level_legal: assert property (@(posedge wclk) disable iff (!wrst_n) diff <= DEPTH_L)
        else $error("wr_level_monitor: illegal fill level %0d", diff);

endmodule

// File: tb/tb_wr_level_monitor.sv
// Self-checking bench for wr_level_monitor: directed vector table, hand-written
// corner sequences and a randomized run against a pointer-level reference model.
module tb_wr_level_monitor;

    localparam int PSW   = 4;
    localparam int DEPTH = 16;
    localparam int SYNC  = 2;

    logic           wclk;
    logic           wrst_n;
    logic [PSW:0]   rptr_gray;
    logic [PSW:0]   wptr_gray;
    logic           winc;
    logic           wfull;
    logic           clr_hwm;
    logic           clr_ovf;
    logic [PSW:0]   wq2_rptr;
    logic [PSW:0]   wlevel;
    logic           walmost_full;
    logic [PSW:0]   whwm;
    logic           wovf;

    int n_checks = 0;
    int n_fail   = 0;

    wr_level_monitor #(
        .ps          (PSW),
        .SYNC_STAGES (SYNC),
        .AF_SET      (12),
        .AF_CLR      (10)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .rptr_gray    (rptr_gray),
        .wptr_gray    (wptr_gray),
        .winc         (winc),
        .wfull        (wfull),
        .clr_hwm      (clr_hwm),
        .clr_ovf      (clr_ovf),
        .wq2_rptr     (wq2_rptr),
        .wlevel       (wlevel),
        .walmost_full (walmost_full),
        .whwm         (whwm),
        .wovf         (wovf)
    );

    // ---------------- clock ----------------
    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    // ---------------- helpers ----------------
    function automatic logic [PSW:0] gray5(input int b);
        logic [PSW:0] x;
        x = b[PSW:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wq2"},   int'(wq2_rptr),     0);
        chk({tag, "_level"}, int'(wlevel),       0);
        chk({tag, "_af"},    int'(walmost_full), 0);
        chk({tag, "_hwm"},   int'(whwm),         0);
        chk({tag, "_ovf"},   int'(wovf),         0);
    endtask

    task automatic drive(input int w, input int r, input bit wi, input bit wf,
                         input bit ch, input bit co);
        wptr_gray = gray5(w);
        rptr_gray = gray5(r);
        winc      = wi;
        wfull     = wf;
        clr_hwm   = ch;
        clr_ovf   = co;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int w; int r; bit wi; bit wf; bit ch; bit co;
        int lvl; bit af; int hwm; bit ovf; int wq2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int w, int r, bit wi, bit wf, bit ch, bit co,
                                int lvl, bit af, int hwm, bit ovf, int wq2);
        vec_t v;
        v.w = w; v.r = r; v.wi = wi; v.wf = wf; v.ch = ch; v.co = co;
        v.lvl = lvl; v.af = af; v.hwm = hwm; v.ovf = ovf; v.wq2 = wq2;
        return v;
    endfunction

    // ---------------- reference model (binary pointers, delay queue) ----------------
    int pipe[$];
    int m_wb, m_rb, m_hwm;
    bit m_af, m_ovf;

    task automatic model_reset();
        pipe = {};
        for (int i = 0; i < SYNC; i++) pipe.push_back(0);
        m_wb = 0; m_rb = 0; m_hwm = 0; m_af = 0; m_ovf = 0;
    endtask

    task automatic rand_step(input int nw, input int nr, input bit wi, input bit wf,
                             input bit ch, input bit co);
        int lvl;
        drive(nw, nr, wi, wf, ch, co);
        lvl = nw - pipe[0];
        if (lvl >= 12) m_af = 1;
        else if (lvl <= 10) m_af = 0;
        if (ch || lvl > m_hwm) m_hwm = lvl;
        if (wi && wf) m_ovf = 1;
        else if (co) m_ovf = 0;
        pipe.push_back(nr);
        void'(pipe.pop_front());
        m_wb = nw;
        m_rb = nr;
        @(posedge wclk);
        #1;
        chk("rnd_level", int'(wlevel),       lvl);
        chk("rnd_af",    int'(walmost_full), int'(m_af));
        chk("rnd_hwm",   int'(whwm),         m_hwm);
        chk("rnd_ovf",   int'(wovf),         int'(m_ovf));
        chk("rnd_wq2",   int'(wq2_rptr),     int'(gray5(pipe[0])));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Reset with arbitrary inputs.
        wrst_n = 1'b1;
        drive($urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        #2 wrst_n = 1'b0;
        #1 chk_all_zero("rst_async");
        @(posedge wclk);
        #1 chk_all_zero("rst_hold");
        drive(0, 0, 0, 0, 0, 0);
        @(negedge wclk);
        wrst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge wclk);
            #1;
            chk("post_rst_level", int'(wlevel), 0);
            chk("post_rst_af",    int'(walmost_full), 0);
        end

        // Fill to full, then read pointer advances through the synchroniser.
        for (int k = 1; k <= DEPTH; k++) tbl.push_back(mk(k, 0, 0, 0, 0, 0, k, k >= 12, k, 0, 0));
        tbl.push_back(mk(16, 5, 0, 0, 0, 0, 16, 1, 16, 0, 0));
        tbl.push_back(mk(16, 5, 0, 0, 0, 0, 16, 1, 16, 0, 5));
        tbl.push_back(mk(16, 5, 0, 0, 0, 0, 11, 1, 16, 0, 5));
        tbl.push_back(mk(16, 6, 0, 0, 0, 0, 11, 1, 16, 0, 5));
        tbl.push_back(mk(16, 6, 0, 0, 0, 0, 11, 1, 16, 0, 6));
        tbl.push_back(mk(16, 6, 0, 0, 0, 0, 10, 0, 16, 0, 6));
        // Overflow set, hold, set-beats-clear, clear.
        tbl.push_back(mk(16, 6, 1, 1, 0, 0, 10, 0, 16, 1, 6));
        tbl.push_back(mk(16, 6, 0, 0, 0, 0, 10, 0, 16, 1, 6));
        tbl.push_back(mk(16, 6, 1, 1, 0, 1, 10, 0, 16, 1, 6));
        tbl.push_back(mk(16, 6, 0, 0, 0, 1, 10, 0, 16, 0, 6));
        tbl.push_back(mk(16, 6, 1, 0, 0, 0, 10, 0, 16, 0, 6));
        // Drain to 7 and clear the high-water mark there.
        tbl.push_back(mk(16, 9, 0, 0, 0, 0, 10, 0, 16, 0, 6));
        tbl.push_back(mk(16, 9, 0, 0, 0, 0, 10, 0, 16, 0, 9));
        tbl.push_back(mk(16, 9, 0, 0, 0, 0,  7, 0, 16, 0, 9));
        tbl.push_back(mk(16, 9, 0, 0, 1, 0,  7, 0,  7, 0, 9));
        tbl.push_back(mk(16, 9, 0, 0, 0, 0,  7, 0,  7, 0, 9));

        foreach (tbl[i]) begin
            drive(tbl[i].w, tbl[i].r, tbl[i].wi, tbl[i].wf, tbl[i].ch, tbl[i].co);
            @(posedge wclk);
            #1;
            chk($sformatf("vec%0d_level", i), int'(wlevel),       tbl[i].lvl);
            chk($sformatf("vec%0d_af", i),    int'(walmost_full), int'(tbl[i].af));
            chk($sformatf("vec%0d_hwm", i),   int'(whwm),         tbl[i].hwm);
            chk($sformatf("vec%0d_ovf", i),   int'(wovf),         int'(tbl[i].ovf));
            chk($sformatf("vec%0d_wq2", i),   int'(wq2_rptr),     int'(gray5(tbl[i].wq2)));
        end

        // Mid-operation reset takes effect between clock edges.
        #3 wrst_n = 1'b0;
        #1 chk_all_zero("rst_mid");

        // Wrap-around: write pointer 3 (wrapped) against read pointer 29.
        drive(3, 29, 0, 0, 0, 0);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1 chk("wrap_lvl0", int'(wlevel), 3);
        @(posedge wclk);
        #1 chk("wrap_wq2", int'(wq2_rptr), int'(gray5(29)));
        @(posedge wclk);
        #1;
        chk("wrap_level", int'(wlevel), 6);
        chk("wrap_hwm",   int'(whwm),   6);
        chk("wrap_af",    int'(walmost_full), 0);

        // Randomized run against the reference model.
        wrst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge wclk);
        wrst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            int nw, nr;
            if (i == 700) begin
                #2 wrst_n = 1'b0;
                #1;
                chk("rnd_rst_level", int'(wlevel), 0);
                chk("rnd_rst_hwm",   int'(whwm),   0);
                drive(0, 0, 0, 0, 0, 0);
                @(negedge wclk);
                wrst_n = 1'b1;
                model_reset();
            end
            nw = m_wb;
            nr = m_rb;
            if ($urandom_range(0, 9) < 6 && (m_wb + 1 - pipe[0]) <= DEPTH) nw = m_wb + 1;
            if ($urandom_range(0, 9) < 4 && m_rb < m_wb) nr = m_rb + 1;
            rand_step(nw, nr, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
